// File: rtl/scu_bus_arbiter.sv
// scu_bus_arbiter: shares the SCU-internal memory port between DSP DMA (0), SCU DMA L0 (1), SCU DMA L1 (2).
// Latency: grant and S_REQ are registered one CE_R cycle after a request is seen in IDLE; M_ACK one CE_R cycle after S_ACK.
// Backpressure: requesters hold M_REQ until M_ACK; the slave stalls by withholding S_ACK, bounded by the TIMEOUT watchdog.
// Ports: CLK/RST_N/CE_R clocking; M_REQ/M_WR/M_A/M_DO requester side in, M_DI/M_ACK back to the owner;
//        S_A/S_DO/S_WR/S_REQ to the slave, S_DI/S_ACK from it; GNT owner index, BUSY transfer flag, ERR timeout pulse.
module scu_bus_arbiter #(
   parameter int PRIO_MODE = 1,
   parameter int TIMEOUT   = 255
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        CE_R,
   input  logic [2:0]  M_REQ,
   input  logic [2:0]  M_WR,
   input  logic [74:0] M_A,
   input  logic [95:0] M_DO,
   output logic [31:0] M_DI,
   output logic [2:0]  M_ACK,
   output logic [24:0] S_A,
   output logic [31:0] S_DO,
   input  logic [31:0] S_DI,
   output logic        S_WR,
   output logic        S_REQ,
   input  logic        S_ACK,
   output logic [1:0]  GNT,
   output logic        BUSY,
   output logic        ERR
);
   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RELEASE} state_t;

   // tmo_cnt holds the number of BUSY cycles already spent without S_ACK, so the
   // abort fires on the cycle where it would reach TIMEOUT.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   logic [1:0]  rr_ptr;
   logic [7:0]  tmo_cnt;
   logic [1:0]  win;
   logic        win_vld;
   logic [1:0]  cand;
   logic [24:0] win_a;
   logic [31:0] win_do;
   logic        win_wr;
   logic [1:0]  rr_next;

   // Candidates are scanned from lowest to highest priority so the last hit is
   // the winner. Round-robin priority starts at rr_ptr and wraps 2->0.
   always_comb begin
      win     = 2'd0;
      win_vld = 1'b0;
      cand    = 2'd0;
      for (int j = 2; j >= 0; j--) begin
         if (PRIO_MODE == 0)
            cand = 2'(j);
         else
            cand = 2'((int'(rr_ptr) + j) % 3);
         if (M_REQ[cand]) begin
            win     = cand;
            win_vld = 1'b1;
         end
      end
   end

   always_comb begin
      case (win)
         2'd1:    begin win_a = M_A[49:25]; win_do = M_DO[63:32]; win_wr = M_WR[1]; end
         2'd2:    begin win_a = M_A[74:50]; win_do = M_DO[95:64]; win_wr = M_WR[2]; end
         default: begin win_a = M_A[24:0];  win_do = M_DO[31:0];  win_wr = M_WR[0]; end
      endcase
   end

   assign rr_next = (win == 2'd2) ? 2'd0 : win + 2'd1;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= ST_IDLE;
         rr_ptr  <= 2'd0;
         tmo_cnt <= 8'd0;
         M_DI    <= 32'd0;
         M_ACK   <= 3'd0;
         S_A     <= 25'd0;
         S_DO    <= 32'd0;
         S_WR    <= 1'b0;
         S_REQ   <= 1'b0;
         GNT     <= 2'd0;
         BUSY    <= 1'b0;
         ERR     <= 1'b0;
      end else if (CE_R) begin
         case (state)
            ST_IDLE: begin
               if (win_vld) begin
                  GNT     <= win;
                  S_A     <= win_a;
                  S_DO    <= win_do;
                  S_WR    <= win_wr;
                  S_REQ   <= 1'b1;
                  BUSY    <= 1'b1;
                  tmo_cnt <= 8'd0;
                  if (PRIO_MODE != 0)
                     rr_ptr <= rr_next;
                  state   <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               // A slave ACK on the final watchdog cycle takes precedence over the abort.
               if (S_ACK) begin
                  M_ACK <= 3'b001 << GNT;
                  S_REQ <= 1'b0;
                  BUSY  <= 1'b0;
                  if (!S_WR)
                     M_DI <= S_DI;
                  state <= ST_RELEASE;
               end else if (tmo_cnt == TMO_LAST) begin
                  M_ACK <= 3'b001 << GNT;
                  ERR   <= 1'b1;
                  M_DI  <= 32'hFFFF_FFFF;
                  S_REQ <= 1'b0;
                  BUSY  <= 1'b0;
                  state <= ST_RELEASE;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            ST_RELEASE: begin
               // One quiet cycle lets the owner drop M_REQ before the next arbitration.
               M_ACK <= 3'd0;
               ERR   <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_scu_bus_arbiter.sv
// tb_scu_bus_arbiter: two arbiters (fixed and round-robin priority, TIMEOUT=4) driven by shared requesters.
// Each arbiter has its own slave model; expected grants and acknowledges come from a queue-based reference model.
// A negedge monitor pops and compares expectations whenever S_REQ rises or M_ACK pulses.
module tb_scu_bus_arbiter;
   localparam int TMO = 4;

   typedef struct { int w; logic [24:0] a; logic [31:0] dat; logic wr; } g_t;
   typedef struct { int w; logic [31:0] di; logic err; int len; } a_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ce_r;
   logic [2:0]  m_req;
   logic [2:0]  mwr;
   logic [24:0] ma [3];
   logic [31:0] mdo [3];
   logic [74:0] m_a;
   logic [95:0] m_do;

   logic [31:0] m_di [2];
   logic [2:0]  m_ack [2];
   logic [24:0] s_a [2];
   logic [31:0] s_do [2];
   logic [31:0] s_di [2];
   logic        s_wr [2];
   logic        s_req [2];
   logic        s_ack [2];
   logic [1:0]  gnt [2];
   logic        busy [2];
   logic        err [2];

   assign m_a  = {ma[2], ma[1], ma[0]};
   assign m_do = {mdo[2], mdo[1], mdo[0]};

   always #5 clk = ~clk;

   scu_bus_arbiter #(.PRIO_MODE(0), .TIMEOUT(TMO)) dut0 (
      .CLK(clk), .RST_N(rst_n), .CE_R(ce_r), .M_REQ(m_req), .M_WR(mwr), .M_A(m_a), .M_DO(m_do),
      .M_DI(m_di[0]), .M_ACK(m_ack[0]), .S_A(s_a[0]), .S_DO(s_do[0]), .S_DI(s_di[0]), .S_WR(s_wr[0]),
      .S_REQ(s_req[0]), .S_ACK(s_ack[0]), .GNT(gnt[0]), .BUSY(busy[0]), .ERR(err[0]));

   scu_bus_arbiter #(.PRIO_MODE(1), .TIMEOUT(TMO)) dut1 (
      .CLK(clk), .RST_N(rst_n), .CE_R(ce_r), .M_REQ(m_req), .M_WR(mwr), .M_A(m_a), .M_DO(m_do),
      .M_DI(m_di[1]), .M_ACK(m_ack[1]), .S_A(s_a[1]), .S_DO(s_do[1]), .S_DI(s_di[1]), .S_WR(s_wr[1]),
      .S_REQ(s_req[1]), .S_ACK(s_ack[1]), .GNT(gnt[1]), .BUSY(busy[1]), .ERR(err[1]));

   int nchk = 0;
   int nerr = 0;

   // reference model state
   g_t          gq [2][$];
   a_t          aq [2][$];
   int          ptr [2];
   logic [31:0] ld [2];
   int          sk;
   logic [31:0] sbase;
   bit          ce_rand;

   // monitor / slave state
   g_t   cur [2];
   logic p_sreq [2];
   logic p_busy [2];
   logic [2:0] p_mack [2];
   int   bcnt [2];
   int   acnt [2];
   int   ack_cnt [2];
   bit   sseen [2];
   int   scnt [2];

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [2:0] req, input int mode, input int p);
      for (int j = 0; j < 3; j++) begin
         int c;
         c = (mode == 0) ? j : (p + j) % 3;
         if (req[c]) return c;
      end
      return -1;
   endfunction

   task automatic monitor(input int d);
      g_t g;
      a_t a;
      if (p_busy[d] && ce_r) bcnt[d]++;
      if (p_mack[d] != 3'd0 && ce_r) acnt[d]++;
      if (s_req[d] && !p_sreq[d]) begin
         bcnt[d] = 0;
         if (gq[d].size() == 0) begin
            chk("unexpected_grant", d, 32'(gnt[d]), 32'hFFFF_FFFF);
         end else begin
            g = gq[d].pop_front();
            cur[d] = g;
            chk("gnt", d, 32'(gnt[d]), 32'(g.w));
            chk("s_a", d, 32'(s_a[d]), 32'(g.a));
            chk("s_do", d, s_do[d], g.dat);
            chk("s_wr", d, 32'(s_wr[d]), 32'(g.wr));
            chk("busy_rise", d, 32'(busy[d]), 32'd1);
         end
      end else if (s_req[d]) begin
         chk("s_a_stable", d, 32'(s_a[d]), 32'(cur[d].a));
         chk("s_do_stable", d, s_do[d], cur[d].dat);
      end
      if (m_ack[d] != 3'd0 && p_mack[d] == 3'd0) begin
         acnt[d] = 0;
         ack_cnt[d]++;
         if (aq[d].size() == 0) begin
            chk("unexpected_ack", d, 32'(m_ack[d]), 32'd0);
         end else begin
            a = aq[d].pop_front();
            chk("m_ack", d, 32'(m_ack[d]), 32'(3'b001 << a.w));
            chk("m_di", d, m_di[d], a.di);
            chk("err", d, 32'(err[d]), 32'(a.err));
            chk("busy_len", d, 32'(bcnt[d]), 32'(a.len));
            chk("busy_fall", d, 32'(busy[d]), 32'd0);
         end
      end
      if (m_ack[d] == 3'd0 && p_mack[d] != 3'd0)
         chk("ack_width", d, 32'(acnt[d]), 32'd1);
      p_sreq[d] = s_req[d];
      p_busy[d] = busy[d];
      p_mack[d] = m_ack[d];
   endtask

   // Slave acknowledges on the sk-th CE_R-enabled cycle after S_REQ rises.
   task automatic slave(input int d);
      if (!s_req[d]) begin
         sseen[d] = 1'b0;
         s_ack[d] = 1'b0;
      end else begin
         if (!sseen[d]) begin
            sseen[d] = 1'b1;
            scnt[d]  = 0;
         end else if (ce_r) begin
            scnt[d]++;
         end
         s_ack[d] = (scnt[d] == sk - 1);
      end
      s_di[d] = sbase ^ {7'd0, s_a[d]};
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         monitor(d);
         slave(d);
      end
      ce_r = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
   end

   task automatic push_model(input logic [2:0] req, input int n, input int k);
      int   w;
      logic e;
      for (int d = 0; d < 2; d++) begin
         for (int t = 0; t < n; t++) begin
            w = pick(req, d, ptr[d]);
            if (d == 1) ptr[d] = (w + 1) % 3;
            gq[d].push_back('{w, ma[w], mdo[w], mwr[w]});
            if (k > TMO) begin
               e = 1'b1;
               ld[d] = 32'hFFFF_FFFF;
            end else begin
               e = 1'b0;
               if (!mwr[w]) ld[d] = sbase ^ {7'd0, ma[w]};
            end
            aq[d].push_back('{w, ld[d], e, (k > TMO) ? TMO : k});
         end
      end
   endtask

   task automatic run_phase(input logic [2:0] req, input int n, input int k, input bit perturb);
      int b0, b1, guard;
      sk = k;
      push_model(req, n, k);
      b0 = ack_cnt[0];
      b1 = ack_cnt[1];
      @(posedge clk); #2;
      m_req = req;
      if (perturb) begin
         guard = 0;
         while (!s_req[0] && guard < 200) begin @(posedge clk); #2; guard++; end
         for (int i = 0; i < 3; i++) begin
            ma[i]  = 25'($urandom);
            mdo[i] = $urandom;
         end
         mwr = 3'($urandom);
      end
      guard = 0;
      while ((ack_cnt[0] - b0 < n || ack_cnt[1] - b1 < n) && guard < 3000) begin
         @(posedge clk); #2;
         guard++;
      end
      if (guard >= 3000) begin
         nchk++;
         nerr++;
         $display("FAIL ack_wait: got %0d/%0d acks expected %0d", ack_cnt[0] - b0, ack_cnt[1] - b1, n);
      end
      m_req = 3'd0;
      guard = 0;
      while ((busy[0] || busy[1] || m_ack[0] != 3'd0 || m_ack[1] != 3'd0) && guard < 200) begin
         @(posedge clk); #2;
         guard++;
      end
      repeat (2) @(posedge clk);
      #2;
      chk("grant_queue_drained", 0, 32'(gq[0].size() + gq[1].size()), 32'd0);
      chk("ack_queue_drained", 0, 32'(aq[0].size() + aq[1].size()), 32'd0);
      gq[0].delete(); gq[1].delete(); aq[0].delete(); aq[1].delete();
   endtask

   task automatic rst_chk(input int d);
      chk("rst_s_req", d, 32'(s_req[d]), 32'd0);
      chk("rst_m_ack", d, 32'(m_ack[d]), 32'd0);
      chk("rst_busy", d, 32'(busy[d]), 32'd0);
      chk("rst_err", d, 32'(err[d]), 32'd0);
      chk("rst_gnt", d, 32'(gnt[d]), 32'd0);
      chk("rst_s_a", d, 32'(s_a[d]), 32'd0);
      chk("rst_s_do", d, s_do[d], 32'd0);
      chk("rst_s_wr", d, 32'(s_wr[d]), 32'd0);
      chk("rst_m_di", d, m_di[d], 32'd0);
   endtask

   task automatic rand_inputs();
      for (int i = 0; i < 3; i++) begin
         ma[i]  = 25'($urandom);
         mdo[i] = $urandom;
      end
      mwr   = 3'($urandom);
      sbase = $urandom;
   endtask

   initial begin
      #900000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      int w, guard;
      rst_n = 1'b0; ce_r = 1'b1; ce_rand = 1'b0; m_req = 3'd0; mwr = 3'd0; sk = 1; sbase = 32'd0;
      for (int i = 0; i < 3; i++) begin ma[i] = 25'd0; mdo[i] = 32'd0; end
      for (int d = 0; d < 2; d++) begin
         ptr[d] = 0; ld[d] = 32'd0; p_sreq[d] = 1'b0; p_busy[d] = 1'b0; p_mack[d] = 3'd0;
         bcnt[d] = 0; acnt[d] = 0; ack_cnt[d] = 0; sseen[d] = 1'b0; scnt[d] = 0;
         s_ack[d] = 1'b0; s_di[d] = 32'd0;
      end
      repeat (3) @(posedge clk);
      #2;
      for (int d = 0; d < 2; d++) rst_chk(d);
      rst_n = 1'b1;

      // single read from requester 0, slave answers on the 2nd BUSY cycle
      ma[0] = 25'h0000002; mdo[0] = 32'h0; mwr = 3'b000;
      sbase = 32'h3333_3331;
      run_phase(3'b001, 1, 2, 1'b0);

      // all requesting: fixed priority keeps granting 0, round-robin rotates 0,1,2
      rand_inputs();
      mwr = 3'b000;
      run_phase(3'b111, 6, 1, 1'b0);

      // write from requester 2 with requester inputs changing during BUSY
      ma[2] = 25'h1ABCDEF; mdo[2] = 32'hDEAD_BEEF; mwr = 3'b100;
      run_phase(3'b100, 1, 3, 1'b1);

      // watchdog: no ACK within 4 cycles aborts; ACK on the 4th cycle wins
      rand_inputs();
      mwr = 3'b000;
      run_phase(3'b001, 1, 5, 1'b0);
      run_phase(3'b001, 1, 4, 1'b0);

      // reset mid-BUSY with requests held; round-robin pointer must return to 0
      rand_inputs();
      mwr = 3'b000;
      run_phase(3'b001, 1, 1, 1'b0);
      sk = 3;
      for (int d = 0; d < 2; d++) begin
         w = pick(3'b111, d, ptr[d]);
         gq[d].push_back('{w, ma[w], mdo[w], mwr[w]});
      end
      @(posedge clk); #2;
      m_req = 3'b111;
      guard = 0;
      while (!s_req[0] && guard < 200) begin @(posedge clk); #2; guard++; end
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) rst_chk(d);
      repeat (2) @(posedge clk);
      #2;
      gq[0].delete(); gq[1].delete();
      for (int d = 0; d < 2; d++) begin ptr[d] = 0; ld[d] = 32'd0; end
      rst_n = 1'b1;
      run_phase(3'b111, 3, 1, 1'b0);

      // CE_R toggling
      ce_rand = 1'b1;
      rand_inputs();
      run_phase(3'b111, 6, 2, 1'b0);

      // randomized traffic
      for (int it = 0; it < 25; it++) begin
         int n;
         rand_inputs();
         ce_rand = 1'($urandom);
         n = $urandom_range(1, 4);
         run_phase(3'($urandom_range(1, 7)), n, $urandom_range(1, 6), (n == 1) ? 1'($urandom) : 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule

// File: doc/scu_bus_arbiter.md
Name: scu_bus_arbiter

Overview:
- Shares one SCU-internal memory port (25-bit word address, 32-bit data, REQ/ACK handshake) between three requesters: DSP DMA (0), SCU DMA level 0 (1), SCU DMA level 1 (2).
- Sits between the requesters and the memory/bus slave.
- Selects a winner, forwards its address, write data and WR to the slave, and returns the ACK and read data to that winner only.
- Supports fixed or round-robin priority and has a slave-timeout watchdog.

Parameters:
- PRIO_MODE, 1, priority scheme: 0 = fixed (requester 0 highest), 1 = round-robin.
- TIMEOUT, 255, number of CE_R cycles in BUSY without S_ACK before the transfer is aborted; range 1..255.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset, asynchronous, active-low.
- CE_R  in  1  clock enable; all state advances only on CLK edges with CE_R=1.
- M_REQ  in  3  per-requester request; level, held until the matching M_ACK.
- M_WR  in  3  per-requester write flag (1 = write).
- M_A  in  75  per-requester word address; requester i uses bits [25i+24:25i], mapping to address bits [26:2].
- M_DO  in  96  per-requester write data; requester i uses bits [32i+31:32i].
- M_DI  out  32  read data returned to the requester being acknowledged.
- M_ACK  out  3  per-requester acknowledge, one CE_R cycle wide.
- S_A  out  25  slave word address [26:2].
- S_DO  out  32  slave write data.
- S_DI  in  32  slave read data; valid when S_ACK=1.
- S_WR  out  1  slave write flag.
- S_REQ  out  1  slave request; level.
- S_ACK  in  1  slave acknowledge; one CE_R cycle.
- GNT  out  2  index of the current owner; holds the last owner when idle.
- BUSY  out  1  1 while in state BUSY.
- ERR  out  1  one-CE_R-cycle pulse on timeout.

Behaviour:
- Reset values (asynchronous): every output is 0, the round-robin pointer is 0, the timeout counter is 0, state is IDLE. Assertion mid-transfer drops S_REQ and M_ACK immediately and abandons the transfer.
- States: IDLE, BUSY, RELEASE. Every transition requires CE_R=1.
- IDLE:
  - If any M_REQ bit is set, pick winner w.
  - Register GNT=w, S_A=M_A[w], S_DO=M_DO[w], S_WR=M_WR[w]; set S_REQ=1 and clear the counter; go to BUSY.
  - With no request, stay in IDLE.
- Winner selection:
  - PRIO_MODE=0: lowest index wins.
  - PRIO_MODE=1: search starts at the pointer and wraps 2->0. The pointer is set to (w+1) mod 3 when w is granted.
- BUSY:
  - S_REQ, S_A, S_DO and S_WR stay stable; requester inputs are ignored, including changes from the owner.
  - On S_ACK=1: M_ACK[GNT]=1 and S_REQ=0. M_DI is loaded with S_DI on reads and holds its previous value on writes. Go to RELEASE.
  - Otherwise the counter increments.
  - When the counter reaches TIMEOUT with S_ACK still 0: M_ACK[GNT]=1, ERR=1, M_DI=32'hFFFFFFFF, S_REQ=0; go to RELEASE. If S_ACK arrives in that same cycle, the ACK wins and ERR stays 0.
- RELEASE:
  - Lasts exactly one CE_R cycle. M_ACK and ERR return to 0 on exit.
  - No arbitration, so the owner has time to drop M_REQ. Then go to IDLE.
  - A requester still asserting M_REQ after RELEASE is treated as a new request.
- Throughput: a zero-wait slave (S_ACK on the first BUSY cycle) gives at most one transfer every 3 CE_R cycles.
- S_ACK in IDLE or RELEASE is ignored.
- M_ACK is one-hot or zero at all times.
- M_DI is shared; only the requester whose M_ACK is high may sample it.
- With CE_R=0, all registers hold.

Test Plan:
1. Only M_REQ=3'b001, read A=25'h0000002, slave returns S_DI=32'h33333333 with S_ACK 2 cycles after S_REQ -> S_A=25'h0000002, S_WR=0, then M_ACK=3'b001 for one CE_R cycle with M_DI=32'h33333333, BUSY=1 for 2 cycles, ERR=0.
2. PRIO_MODE=0, M_REQ=3'b111 held, each requester re-raises M_REQ after its ACK -> grant order 0,0,0...; requesters 1 and 2 are never acknowledged while 0 keeps requesting.
3. PRIO_MODE=1, M_REQ=3'b111 held, each requester re-raises M_REQ after its ACK -> grant order 0,1,2,0,1,2 (GNT sequence checked); each M_ACK goes to the matching bit.
4. Write from requester 2, A=25'h1ABCDEF, DO=32'hDEADBEEF -> S_WR=1, S_A and S_DO match and stay stable through BUSY; M_DI is unchanged after M_ACK[2].
5. TIMEOUT=4, slave never acknowledges -> ERR pulses exactly 4 CE_R cycles after BUSY rises, M_DI=32'hFFFFFFFF, M_ACK pulses, then IDLE; repeat with S_ACK on the 4th cycle -> ERR=0, slave data returned.
6. Assert RST_N=0 mid-BUSY and hold M_REQ; toggle CE_R during a transfer -> outputs 0 asynchronously, RR pointer back to 0, clean re-arbitration after release; state frozen while CE_R=0.
